// File: rtl/wb_ram_burst.sv
// rtl/wb_ram_burst.sv - Wishbone RAM slave with wait states, byte lanes, registered-feedback bursts and error response
module wb_ram_burst #(
    parameter int    DW          = 16,
    parameter int    AW          = 16,
    parameter int    DEPTH_LOG2  = 10,
    parameter int    WAIT_CYCLES = 0,
    parameter string INITFILE    = "none"
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   adr_i,
    input  logic [DW-1:0]   dat_i,
    output logic [DW-1:0]   dat_o,
    input  logic            we_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic [2:0]      cti_i,
    input  logic [1:0]      bte_i,
    output logic            ack_o,
    output logic            err_o
);

    localparam int NB    = DW / 8;
    localparam int OFFB  = (NB > 1) ? $clog2(NB) : 0;
    localparam int WW    = AW - OFFB;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_BURST
    } state_t;

    state_t                state_q;
    logic [WW-1:0]         adr_q;
    logic                  we_q;
    logic [1:0]            bte_q;
    logic [3:0]            cnt_q;
    logic                  burst_q;
    logic                  ack_q;
    logic                  err_q;
    logic [DW-1:0]         dat_q;

    logic [DW-1:0]         mem [0:DEPTH-1];

    logic [WW-1:0]         w_in;
    logic                  beat_go;
    logic [WW-1:0]         beat_adr;
    logic                  beat_we;
    logic                  beat_ovf;
    logic                  beat_ok;
    logic [DEPTH_LOG2-1:0] beat_idx;
    logic                  mem_we;
    logic                  unused_adr;

    assign w_in       = adr_i[AW-1:OFFB];
    assign unused_adr = ^adr_i;
    assign beat_idx   = beat_adr[DEPTH_LOG2-1:0];

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;

    // Next burst word: low bits count modulo the wrap size, upper bits held
    function automatic logic [WW-1:0] next_adr(input logic [WW-1:0] a, input logic [1:0] bte);
        logic [WW-1:0] mask;
        logic [WW-1:0] inc;
        case (bte)
            2'b01:   mask = WW'(3);
            2'b10:   mask = WW'(7);
            2'b11:   mask = WW'(15);
            default: mask = '1;
        endcase
        inc = a + WW'(1);
        return (a & ~mask) | (inc & mask);
    endfunction

    // Decide whether a beat is issued on this edge, and for which word
    always_comb begin
        beat_go  = 1'b0;
        beat_adr = adr_q;
        beat_we  = we_q;
        beat_ovf = 1'b0;
        case (state_q)
            S_IDLE: begin
                beat_adr = w_in;
                beat_we  = we_i;
                beat_go  = cyc_i && stb_i && (WAIT_CYCLES == 0);
            end
            S_WAIT: begin
                beat_go = cyc_i && (cnt_q == 4'd1);
            end
            S_RESP, S_BURST: begin
                beat_adr = next_adr(adr_q, bte_q);
                beat_ovf = (bte_q == 2'b00) && (adr_q == WW'(DEPTH - 1));
                beat_go  = cyc_i && stb_i && ((state_q == S_BURST) || burst_q);
            end
            default: beat_go = 1'b0;
        endcase
        beat_ok = ((beat_adr >> DEPTH_LOG2) == '0) && !beat_ovf;
        mem_we  = beat_go && beat_ok && beat_we && !rst_i;
    end

    // Byte-lane write, committed on the edge that raises ack
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (sel_i[b]) begin
                    mem[beat_idx][b*8 +: 8] <= dat_i[b*8 +: 8];
                end
            end
        end
    end

    // Cycle FSM with registered ack/err/read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            bte_q   <= 2'b00;
            cnt_q   <= 4'd0;
            burst_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (beat_go) begin
                if (beat_ok) begin
                    ack_q <= 1'b1;
                    dat_q <= mem[beat_idx];
                end else begin
                    err_q <= 1'b1;
                    dat_q <= '0;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (cyc_i && stb_i) begin
                        adr_q <= w_in;
                        we_q  <= we_i;
                        bte_q <= bte_i;
                        cnt_q <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                            burst_q <= (cti_i == 3'b010) && beat_ok;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!cyc_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= S_RESP;
                            burst_q <= (cti_i == 3'b010) && beat_ok;
                        end
                    end
                end
                S_RESP, S_BURST: begin
                    if (!cyc_i || (state_q == S_RESP && !burst_q)) begin
                        state_q <= S_IDLE;
                        burst_q <= 1'b0;
                    end else if (beat_go) begin
                        adr_q <= beat_adr;
                        if (!beat_ok || cti_i == 3'b111) begin
                            state_q <= S_RESP;
                            burst_q <= 1'b0;
                        end else begin
                            state_q <= S_BURST;
                        end
                    end else begin
                        state_q <= S_BURST;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_burst.sv
// tb/tb_wb_ram_burst.sv - self-checking bench for wb_ram_burst (zero-wait and three-wait instances)
module tb_wb_ram_burst;

    logic        clk;
    logic        rst;
    logic [15:0] adr;
    logic [15:0] dat_w;
    logic        we;
    logic [1:0]  sel;
    logic        cyc0, cyc3;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [15:0] dat0, dat3;
    logic        ack0, err0, ack3, err3;

    int errors = 0;
    int checks = 0;

    logic [15:0] mdl [0:1][0:1023];

    bit          s_stb [0:19];
    logic [2:0]  s_cti [0:19];
    logic [15:0] s_dat [0:19];
    logic [17:0] rec   [0:20];

    wb_ram_burst #(.DW(16), .AW(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0), .INITFILE("none")) u_dut0 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat0), .we_i(we), .sel_i(sel),
        .cyc_i(cyc0), .stb_i(stb), .cti_i(cti), .bte_i(bte), .ack_o(ack0), .err_o(err0)
    );

    wb_ram_burst #(.DW(16), .AW(16), .DEPTH_LOG2(10), .WAIT_CYCLES(3), .INITFILE("none")) u_dut3 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat3), .we_i(we), .sel_i(sel),
        .cyc_i(cyc3), .stb_i(stb), .cti_i(cti), .bte_i(bte), .ack_o(ack3), .err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] outs(input int which);
        return (which == 0) ? {ack0, err0, dat0} : {ack3, err3, dat3};
    endfunction

    task automatic set_cyc(input int which, input bit v);
        if (which == 0) cyc0 = v;
        else cyc3 = v;
    endtask

    task automatic mwrite(input int which, input int word, input logic [15:0] d, input logic [1:0] s);
        if (s[0]) mdl[which][word][7:0]  = d[7:0];
        if (s[1]) mdl[which][word][15:8] = d[15:8];
    endtask

    function automatic int wrap_word(input int start, input int nw, input int k);
        if (nw == 0) return start + k;
        return start - (start % nw) + ((start % nw) + k) % nw;
    endfunction

    // One classic cycle; returns latency in cycles from stb (or -1), the response and the following cycle
    task automatic bus_classic(input int which, input bit w, input logic [15:0] a, input logic [15:0] d,
                               input logic [1:0] s, output int lat, output logic [17:0] obs, output logic [17:0] nxt);
        logic [17:0] o;
        adr = a; dat_w = d; we = w; sel = s; cti = 3'b000; bte = 2'b00; stb = 1'b1;
        set_cyc(which, 1'b1);
        lat = -1;
        obs = '0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            o = outs(which);
            if (o[17] || o[16]) begin
                lat = n;
                obs = o;
                break;
            end
        end
        stb = 1'b0; we = 1'b0;
        set_cyc(which, 1'b0);
        tick();
        nxt = outs(which);
    endtask

    // Drive n scheduled burst cycles (stb/cti/data per cycle), then drop cyc for one recorded cycle
    task automatic run_burst(input int which, input bit w, input logic [15:0] a, input logic [1:0] b, input int n);
        adr = a; we = w; bte = b; sel = 2'b11;
        set_cyc(which, 1'b1);
        for (int i = 0; i < n; i++) begin
            stb = s_stb[i]; cti = s_cti[i]; dat_w = s_dat[i];
            if (i > 0) adr = 16'($urandom);
            tick();
            rec[i] = outs(which);
        end
        stb = 1'b0; cti = 3'b000; we = 1'b0;
        set_cyc(which, 1'b0);
        tick();
        rec[n] = outs(which);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) tick();
        checks++; if (outs(0) !== 18'h0) begin errors++; $display("FAIL reset_dut0: got %h want 0", outs(0)); end
        checks++; if (outs(1) !== 18'h0) begin errors++; $display("FAIL reset_dut3: got %h want 0", outs(1)); end
        rst = 1'b0;
        tick();
        checks++; if ({outs(0), outs(1)} !== 36'h0) begin errors++; $display("FAIL reset_release: got %h want 0", {outs(0), outs(1)}); end
    endtask

    task automatic test_classic();
        int lat;
        logic [17:0] obs, nxt;
        int word;
        logic [15:0] d;
        logic [1:0] s;
        bus_classic(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, obs, nxt);
        mwrite(0, 8, 16'hBEEF, 2'b11);
        checks++; if (lat !== 1) begin errors++; $display("FAIL classic_wr_lat: got %0d want 1", lat); end
        checks++; if (obs[17:16] !== 2'b10) begin errors++; $display("FAIL classic_wr_ack: got %b want 10", obs[17:16]); end
        checks++; if (nxt[17:16] !== 2'b00) begin errors++; $display("FAIL classic_ack_drop: got %b want 00", nxt[17:16]); end
        bus_classic(0, 1'b0, 16'h0010, 16'h0000, 2'b11, lat, obs, nxt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL classic_rd_lat: got %0d want 1", lat); end
        checks++; if (obs !== {2'b10, 16'hBEEF}) begin errors++; $display("FAIL classic_rd: got %h want %h", obs, {2'b10, 16'hBEEF}); end
        for (int i = 0; i < 8; i++) begin
            word = $urandom_range(16, 63);
            d = 16'($urandom);
            bus_classic(0, 1'b1, 16'(word * 2), d, 2'b11, lat, obs, nxt);
            mwrite(0, word, d, 2'b11);
            d = 16'($urandom);
            s = 2'($urandom_range(1, 3));
            bus_classic(0, 1'b1, 16'(word * 2 + 1), d, s, lat, obs, nxt);
            checks++; if (obs !== {2'b10, mdl[0][word]}) begin errors++; $display("FAIL classic_prewrite: got %h want %h", obs, {2'b10, mdl[0][word]}); end
            mwrite(0, word, d, s);
            bus_classic(0, 1'b0, 16'(word * 2), 16'h0, 2'b11, lat, obs, nxt);
            checks++; if (obs !== {2'b10, mdl[0][word]}) begin errors++; $display("FAIL classic_lanes w%0d: got %h want %h", word, obs, {2'b10, mdl[0][word]}); end
        end
    endtask

    task automatic test_wait_lanes();
        int lat;
        logic [17:0] obs, nxt;
        int word;
        logic [15:0] d;
        logic [1:0] s;
        bus_classic(1, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, obs, nxt);
        mwrite(1, 8, 16'hBEEF, 2'b11);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wait_wr_lat: got %0d want 4", lat); end
        bus_classic(1, 1'b1, 16'h0010, 16'h0012, 2'b01, lat, obs, nxt);
        mwrite(1, 8, 16'h0012, 2'b01);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wait_lane_lat: got %0d want 4", lat); end
        checks++; if (obs !== {2'b10, 16'hBEEF}) begin errors++; $display("FAIL wait_lane_prewrite: got %h want %h", obs, {2'b10, 16'hBEEF}); end
        checks++; if (nxt[17:16] !== 2'b00) begin errors++; $display("FAIL wait_ack_drop: got %b want 00", nxt[17:16]); end
        bus_classic(1, 1'b0, 16'h0010, 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wait_rd_lat: got %0d want 4", lat); end
        checks++; if (obs !== {2'b10, 16'hBE12}) begin errors++; $display("FAIL wait_rd: got %h want %h", obs, {2'b10, 16'hBE12}); end
        for (int i = 0; i < 4; i++) begin
            word = $urandom_range(16, 63);
            d = 16'($urandom);
            bus_classic(1, 1'b1, 16'(word * 2), d, 2'b11, lat, obs, nxt);
            mwrite(1, word, d, 2'b11);
            d = 16'($urandom);
            s = 2'($urandom_range(1, 2));
            bus_classic(1, 1'b1, 16'(word * 2), d, s, lat, obs, nxt);
            mwrite(1, word, d, s);
            bus_classic(1, 1'b0, 16'(word * 2), 16'h0, 2'b11, lat, obs, nxt);
            checks++; if (obs !== {2'b10, mdl[1][word]} || lat !== 4) begin errors++; $display("FAIL wait_lanes w%0d: got %h lat %0d want %h lat 4", word, obs, lat, {2'b10, mdl[1][word]}); end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] o;
        logic [9:0] pat, exp_pat;
        for (int which = 0; which < 2; which++) begin
            int wc;
            wc = (which == 0) ? 0 : 3;
            adr = 16'h0010; we = 1'b0; sel = 2'b11; cti = 3'b000; stb = 1'b1;
            set_cyc(which, 1'b1);
            pat = '0; exp_pat = '0;
            for (int i = 0; i < 10; i++) begin
                tick();
                o = outs(which);
                pat = {pat[8:0], o[17]};
                exp_pat = {exp_pat[8:0], ((i % (wc + 2)) == wc) ? 1'b1 : 1'b0};
                if (o[17]) begin
                    checks++; if (o[15:0] !== mdl[which][8]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", which, o[15:0], mdl[which][8]); end
                end
            end
            checks++; if (pat !== exp_pat) begin errors++; $display("FAIL b2b_ack_pattern%0d: got %b want %b", which, pat, exp_pat); end
            stb = 1'b0;
            set_cyc(which, 1'b0);
            tick();
            tick();
        end
    endtask

    task automatic test_wrap_burst();
        int lat;
        logic [17:0] obs, nxt;
        for (int k = 0; k < 4; k++) begin
            bus_classic(0, 1'b1, 16'((4 + k) * 2), 16'(16'hA0 + k), 2'b11, lat, obs, nxt);
            mwrite(0, 4 + k, 16'(16'hA0 + k), 2'b11);
        end
        for (int k = 0; k < 4; k++) begin
            s_stb[k] = 1'b1; s_cti[k] = (k == 3) ? 3'b111 : 3'b010; s_dat[k] = 16'h0;
        end
        run_burst(0, 1'b0, 16'd12, 2'b01, 4);
        for (int k = 0; k < 4; k++) begin
            checks++; if (rec[k] !== {2'b10, mdl[0][wrap_word(6, 4, k)]}) begin errors++; $display("FAIL wrap4_beat%0d: got %h want %h", k, rec[k], {2'b10, mdl[0][wrap_word(6, 4, k)]}); end
        end
        checks++; if (rec[4][17:16] !== 2'b00) begin errors++; $display("FAIL wrap4_end: got %b want 00", rec[4][17:16]); end
    endtask

    task automatic test_wrap_random();
        int lat;
        logic [17:0] obs, nxt;
        int nw, start, base;
        logic [15:0] acks, exp_acks;
        for (int bt = 1; bt <= 3; bt++) begin
            nw = 2 << bt;
            start = $urandom_range(256, 511);
            for (int k = 0; k < nw; k++) begin
                s_stb[k] = 1'b1; s_cti[k] = (k == nw - 1) ? 3'b111 : 3'b010; s_dat[k] = 16'($urandom);
            end
            run_burst(0, 1'b1, 16'(start * 2), 2'(bt), nw);
            acks = '0; exp_acks = '0;
            for (int k = 0; k < nw; k++) begin
                acks[k] = rec[k][17];
                exp_acks[k] = 1'b1;
                mwrite(0, wrap_word(start, nw, k), s_dat[k], 2'b11);
            end
            checks++; if (acks !== exp_acks || rec[nw][17:16] !== 2'b00) begin errors++; $display("FAIL wrap%0d_wr_acks: got %h/%b want %h/00", nw, acks, rec[nw][17:16], exp_acks); end
            base = start - (start % nw);
            for (int k = 0; k < nw; k++) begin
                bus_classic(0, 1'b0, 16'((base + k) * 2), 16'h0, 2'b11, lat, obs, nxt);
                checks++; if (obs !== {2'b10, mdl[0][base + k]}) begin errors++; $display("FAIL wrap%0d_rd w%0d: got %h want %h", nw, base + k, obs, {2'b10, mdl[0][base + k]}); end
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [17:0] obs, nxt, exp;
        int beat;
        logic [15:0] last;
        for (int k = 0; k < 4; k++) begin
            exp[15:0] = 16'($urandom);
            bus_classic(0, 1'b1, 16'(k * 2), exp[15:0], 2'b11, lat, obs, nxt);
            mwrite(0, k, exp[15:0], 2'b11);
        end
        s_stb[0] = 1; s_stb[1] = 1; s_stb[2] = 0; s_stb[3] = 0; s_stb[4] = 1; s_stb[5] = 1;
        for (int i = 0; i < 6; i++) begin
            s_cti[i] = (i == 5) ? 3'b111 : 3'b010; s_dat[i] = 16'h0;
        end
        run_burst(0, 1'b0, 16'h0000, 2'b00, 6);
        beat = 0; last = '0;
        for (int i = 0; i < 6; i++) begin
            if (s_stb[i]) begin
                exp = {2'b10, mdl[0][beat]};
                last = mdl[0][beat];
                beat++;
            end else begin
                exp = {2'b00, last};
            end
            checks++; if (rec[i] !== exp) begin errors++; $display("FAIL stall_cycle%0d: got %h want %h", i, rec[i], exp); end
        end
        checks++; if (rec[6][17:16] !== 2'b00) begin errors++; $display("FAIL stall_end: got %b want 00", rec[6][17:16]); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [17:0] obs, nxt;
        for (int i = 0; i < 3; i++) begin
            s_stb[i] = 1'b1; s_cti[i] = 3'b010; s_dat[i] = 16'($urandom);
        end
        run_burst(0, 1'b1, 16'(1022 * 2), 2'b00, 3);
        checks++; if (rec[0][17:16] !== 2'b10 || rec[1][17:16] !== 2'b10) begin errors++; $display("FAIL top_acks: got %b %b want 10 10", rec[0][17:16], rec[1][17:16]); end
        checks++; if (rec[2] !== {2'b01, 16'h0}) begin errors++; $display("FAIL top_err: got %h want %h", rec[2], {2'b01, 16'h0}); end
        checks++; if (rec[3][17:16] !== 2'b00) begin errors++; $display("FAIL top_end: got %b want 00", rec[3][17:16]); end
        mwrite(0, 1022, s_dat[0], 2'b11);
        mwrite(0, 1023, s_dat[1], 2'b11);
        bus_classic(0, 1'b0, 16'(1022 * 2), 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (obs !== {2'b10, mdl[0][1022]}) begin errors++; $display("FAIL top_rd1022: got %h want %h", obs, {2'b10, mdl[0][1022]}); end
        bus_classic(0, 1'b0, 16'(1023 * 2), 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (obs !== {2'b10, mdl[0][1023]}) begin errors++; $display("FAIL top_rd1023: got %h want %h", obs, {2'b10, mdl[0][1023]}); end
        bus_classic(0, 1'b0, 16'h0000, 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (obs !== {2'b10, mdl[0][0]}) begin errors++; $display("FAIL top_word0: got %h want %h", obs, {2'b10, mdl[0][0]}); end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [17:0] obs, nxt;
        bus_classic(0, 1'b0, 16'h0800, 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (lat !== 1 || obs !== {2'b01, 16'h0}) begin errors++; $display("FAIL oor_read: got %h lat %0d want %h lat 1", obs, lat, {2'b01, 16'h0}); end
        checks++; if (nxt[17:16] !== 2'b00) begin errors++; $display("FAIL oor_err_drop: got %b want 00", nxt[17:16]); end
        bus_classic(0, 1'b1, 16'h0802, 16'($urandom), 2'b11, lat, obs, nxt);
        checks++; if (obs[17:16] !== 2'b01) begin errors++; $display("FAIL oor_write: got %b want 01", obs[17:16]); end
        bus_classic(0, 1'b0, 16'h0002, 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (obs !== {2'b10, mdl[0][1]}) begin errors++; $display("FAIL oor_no_alias: got %h want %h", obs, {2'b10, mdl[0][1]}); end
        s_stb[0] = 1'b1; s_stb[1] = 1'b1; s_cti[0] = 3'b010; s_cti[1] = 3'b010; s_dat[0] = 0; s_dat[1] = 0;
        run_burst(0, 1'b0, 16'h0800, 2'b00, 2);
        checks++; if (rec[0] !== {2'b01, 16'h0} || rec[1][17:16] !== 2'b00 || rec[2][17:16] !== 2'b00) begin errors++; $display("FAIL oor_burst: got %h %h %h want err then idle", rec[0], rec[1], rec[2]); end
        bus_classic(1, 1'b0, 16'hFFFE, 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (lat !== 4 || obs !== {2'b01, 16'h0}) begin errors++; $display("FAIL oor_wait: got %h lat %0d want %h lat 4", obs, lat, {2'b01, 16'h0}); end
    endtask

    task automatic test_abort();
        int lat, resp;
        logic [17:0] obs, nxt, o;
        logic [15:0] d;
        d = 16'($urandom);
        bus_classic(1, 1'b1, 16'h0050, d, 2'b11, lat, obs, nxt);
        mwrite(1, 40, d, 2'b11);
        adr = 16'h0050; dat_w = ~d; we = 1'b1; sel = 2'b11; cti = 3'b000; stb = 1'b1; cyc3 = 1'b1;
        tick();
        resp = 0;
        o = outs(1);
        if (o[17] || o[16]) resp++;
        cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            o = outs(1);
            if (o[17] || o[16]) resp++;
        end
        checks++; if (resp !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d responses want 0", resp); end
        bus_classic(1, 1'b0, 16'h0050, 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (obs !== {2'b10, mdl[1][40]}) begin errors++; $display("FAIL abort_mem: got %h want %h", obs, {2'b10, mdl[1][40]}); end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        logic [17:0] obs, nxt, o;
        logic [15:0] d0;
        bus_classic(0, 1'b1, 16'h00C8, 16'($urandom), 2'b11, lat, obs, nxt);
        mwrite(0, 100, adr, 2'b00);
        mwrite(0, 100, dat_w, 2'b11);
        bus_classic(0, 1'b1, 16'h00CA, 16'($urandom), 2'b11, lat, obs, nxt);
        mwrite(0, 101, dat_w, 2'b11);
        d0 = 16'($urandom);
        adr = 16'h00C8; we = 1'b1; sel = 2'b11; cti = 3'b010; bte = 2'b00; dat_w = d0; stb = 1'b1; cyc0 = 1'b1;
        tick();
        o = outs(0);
        checks++; if (o[17:16] !== 2'b10) begin errors++; $display("FAIL rstburst_beat1: got %b want 10", o[17:16]); end
        dat_w = ~d0;
        rst = 1'b1;
        tick();
        checks++; if ({outs(0), outs(1)} !== 36'h0) begin errors++; $display("FAIL rstburst_outs: got %h want 0", {outs(0), outs(1)}); end
        rst = 1'b0; cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        tick();
        mwrite(0, 100, d0, 2'b11);
        bus_classic(0, 1'b0, 16'h00C8, 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (obs !== {2'b10, mdl[0][100]}) begin errors++; $display("FAIL rstburst_kept: got %h want %h", obs, {2'b10, mdl[0][100]}); end
        bus_classic(0, 1'b0, 16'h00CA, 16'h0, 2'b11, lat, obs, nxt);
        checks++; if (obs !== {2'b10, mdl[0][101]}) begin errors++; $display("FAIL rstburst_dropped: got %h want %h", obs, {2'b10, mdl[0][101]}); end
    endtask

    initial begin
        rst = 1'b1; adr = '0; dat_w = '0; we = 1'b0; sel = 2'b00;
        cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
        test_reset();
        test_classic();
        test_wait_lanes();
        test_back_to_back();
        test_wrap_burst();
        test_wrap_random();
        test_stall();
        test_overflow();
        test_out_of_range();
        test_abort();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
